qpsk_carrier_ctrl: RTL and testbench
====================================

Name: qpsk_carrier_ctrl

Overview:
- Sequences the 16-entry, 8-bit cosine carrier table for QPSK modulation.
- Accepts 2-bit symbols over a valid/ready handshake into a 2-entry buffer.
- Maps each symbol to a phase offset and emits one table address per clock, holding each symbol for a whole number of carrier periods.
- Sits between the symbol source and the I/Q carrier lookups. I-path uses cos_addr; Q-path uses sin_addr into the same table.

Parameters:
- PERIODS_PER_SYM, 1, carrier periods (16 samples each) per symbol; range 1..16.
- ADDR_W, 4, table address width; fixed at 4 (16 entries).

Ports:
- clk  input  1  sample clock, rising edge
- rst  input  1  asynchronous, active-high reset
- sym_valid  input  1  symbol offered
- sym_data  input  2  Gray-coded QPSK symbol
- sym_ready  output  1  buffer can accept a symbol
- out_valid  output  1  cos_addr/sin_addr are valid this cycle
- cos_addr  output  4  in-phase table address
- sin_addr  output  4  quadrature table address, equal to cos_addr+12 mod 16
- sym_start  output  1  first sample of a symbol
- starve  output  1  one-cycle pulse: symbol ended with the buffer empty
- underflow_cnt  output  8  starve event count (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, cos_addr=0, sin_addr=12, sym_start=0, starve=0, underflow_cnt=0, buffer empty, FSM=IDLE. sym_ready=0 while rst is high.
- Handshake: sym_ready = !rst && (buffer count < 2). A push occurs on an edge where sym_valid && sym_ready. A push and a pop on the same edge are legal and leave the count unchanged.
- Phase offset by sym_data: 00→2, 01→6, 11→10, 10→14 (45°/135°/225°/315° at 22.5° per step).
- sample_cnt runs 0..16*PERIODS_PER_SYM-1. Width is 8 bits.
- All outputs are registered. cos_addr = (sample_cnt[3:0] + offset) mod 16, using 4-bit wrap.
- FSM IDLE:
  - out_valid=0.
  - If the buffer is non-empty, pop on this edge and enter RUN, with sample_cnt=0 and sym_start=1 on the next cycle.
  - Latency: the first out_valid comes 2 edges after the accepting edge when the block starts IDLE and empty.
- FSM RUN:
  - out_valid=1. sample_cnt increments each edge.
  - At the edge leaving the last sample, if the buffer is non-empty: pop, load the new offset, set sample_cnt=0 and sym_start=1. Output is seamless with no gap cycle.
  - If the buffer is empty: go to IDLE, out_valid=0 and starve=1 for one cycle.
- A symbol pushed on the same edge as the last-sample pop check is not visible to that check. This still produces starve plus IDLE, then a restart via IDLE.
- sym_start and starve are single-cycle pulses.
- Reset asserted mid-symbol: outputs return to reset values immediately. Buffer contents are discarded. No starve pulse is generated.

Optional Feature:
- Macro: QPSK_UNDERFLOW_CNT_EN.
- Defined: underflow_cnt increments on each starve pulse and saturates at 255. Cleared only by rst.
- Undefined: underflow_cnt is tied to 0 and no counter logic is synthesized. The port remains present.

Decomposition:
- Package qpsk_pkg holds:
  - LUT_DEPTH=16, ADDR_W=4, Q_SHIFT=12
  - the 4 phase-offset constants
  - the FSM state typedef {IDLE, RUN}
- Sub-module sym_buffer: a 2-entry FIFO with 2-bit data, push/pop, count, and full/empty flags. It is the natural split from the FSM and address generator.

Test Plan:
- Reset values: assert rst asynchronously mid-cycle → out_valid=0, cos_addr=0, sin_addr=12, sym_ready=0, all without waiting for a clock edge. Release → sym_ready=1.
- Single symbol 00, PERIODS_PER_SYM=1:
  - out_valid high for exactly 16 cycles.
  - cos_addr sequence 2,3,…,15,0,1; sin_addr sequence 14,15,0,…,13.
  - sym_start on the first sample; starve=1 on the cycle after the last sample.
- Back-to-back symbols 01 then 11, both pushed early:
  - 32 consecutive valid cycles with no gap.
  - The second symbol starts at cos_addr=10 with sym_start=1 at sample 16.
  - No starve until the end.
- Full buffer: hold sym_valid=1 while RUN → sym_ready drops after 2 accepts and rises on the pop edge. No symbol is lost or duplicated (scoreboard over 20 random symbols).
- Reset mid-symbol: assert rst at sample 7 of symbol 10 with one symbol buffered → immediate reset values. After release, no output until a new push; the old buffered symbol never appears.
- With QPSK_UNDERFLOW_CNT_EN: 300 isolated single-symbol bursts → underflow_cnt saturates at 255. Without the macro it stays 0.

Source files
------------

// File: rtl/qpsk_pkg.sv
// qpsk_pkg: shared constants, state type and phase mapping for the
// QPSK carrier sequencer (qpsk_carrier_ctrl and its symbol buffer).
package qpsk_pkg;

    localparam int LUT_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int Q_SHIFT   = 12;
    localparam int SYM_W     = 2;

    // Phase offsets in 22.5 degree steps for each Gray-coded symbol
    localparam logic [3:0] PHASE_00 = 4'd2;
    localparam logic [3:0] PHASE_01 = 4'd6;
    localparam logic [3:0] PHASE_11 = 4'd10;
    localparam logic [3:0] PHASE_10 = 4'd14;

    // Sequencer state encoding
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    // Map a symbol onto its carrier table phase offset
    function automatic logic [3:0] phase_offset(input logic [SYM_W-1:0] sym);
        logic [3:0] off;
        off = PHASE_00;
        case (sym)
            2'b00: off = PHASE_00;
            2'b01: off = PHASE_01;
            2'b11: off = PHASE_11;
            2'b10: off = PHASE_10;
            default: off = PHASE_00;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/qpsk_carrier_ctrl_sym_buffer.sv
// sym_buffer: two-entry symbol FIFO between the handshake and the sequencer.
// Push is ignored when full and pop when empty, so callers may be sloppy.
module sym_buffer
    import qpsk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [SYM_W-1:0] push_data,
    input  logic             pop,
    output logic [SYM_W-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    logic [SYM_W-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage, pointers and occupancy; a simultaneous push and pop keeps the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 2'd1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule

// File: rtl/qpsk_carrier_ctrl.sv
// qpsk_carrier_ctrl: turns buffered QPSK symbols into a stream of cosine
// and sine carrier table addresses, one per clock, whole carrier periods
// per symbol. Optional saturating starve counter under QPSK_UNDERFLOW_CNT_EN.
module qpsk_carrier_ctrl #(
    parameter int PERIODS_PER_SYM = 1,
    parameter int ADDR_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    input  logic [1:0]        sym_data,
    output logic              sym_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] cos_addr,
    output logic [ADDR_W-1:0] sin_addr,
    output logic              sym_start,
    output logic              starve,
    output logic [7:0]        underflow_cnt
);
    import qpsk_pkg::*;

    localparam logic [7:0] LAST_SAMPLE = 8'(LUT_DEPTH * PERIODS_PER_SYM - 1);

    logic              buf_full;
    logic              buf_empty;
    logic [1:0]        buf_head;
    logic              push;
    logic              pop;
    state_t            state;
    logic [7:0]        sample_cnt;
    logic [ADDR_W-1:0] offset;
    logic              last_sample;
    logic [ADDR_W-1:0] addr_next;

    assign sym_ready   = !rst && !buf_full;
    assign push        = sym_valid && sym_ready;
    assign last_sample = (sample_cnt == LAST_SAMPLE);
    assign pop         = !buf_empty && ((state == IDLE) || last_sample);
    assign addr_next   = sample_cnt[ADDR_W-1:0] + offset;

    sym_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (sym_data),
        .pop       (pop),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    // Sequencer: start from IDLE when a symbol waits, chain symbols at the last sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= 8'd0;
            offset     <= '0;
        end else if (state == IDLE) begin
            if (!buf_empty) begin
                state      <= RUN;
                sample_cnt <= 8'd0;
                offset     <= phase_offset(buf_head);
            end
        end else begin
            if (last_sample) begin
                if (!buf_empty) begin
                    sample_cnt <= 8'd0;
                    offset     <= phase_offset(buf_head);
                end else begin
                    state <= IDLE;
                end
            end else begin
                sample_cnt <= sample_cnt + 8'd1;
            end
        end
    end

    // Output register stage; starve marks the first idle cycle after a run
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            cos_addr  <= '0;
            sin_addr  <= ADDR_W'(Q_SHIFT);
            sym_start <= 1'b0;
            starve    <= 1'b0;
        end else begin
            out_valid <= (state == RUN);
            cos_addr  <= addr_next;
            sin_addr  <= addr_next + ADDR_W'(Q_SHIFT);
            sym_start <= (state == RUN) && (sample_cnt == 8'd0);
            starve    <= out_valid && (state == IDLE);
        end
    end

`ifdef QPSK_UNDERFLOW_CNT_EN
    logic [7:0] uf_cnt;

    // Saturating count of starve pulses, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uf_cnt <= 8'd0;
        end else if (starve && (uf_cnt != 8'hFF)) begin
            uf_cnt <= uf_cnt + 8'd1;
        end
    end

    assign underflow_cnt = uf_cnt;
`else
    assign underflow_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_qpsk_carrier_ctrl.sv
// tb_qpsk_carrier_ctrl: randomized and directed bench for qpsk_carrier_ctrl
// with a symbol-level reference model, per-cycle compare and a symbol scoreboard.
module tb_qpsk_carrier_ctrl;

    localparam int P       = 1;
    localparam int SYM_LEN = 16 * P;

    logic       clk;
    logic       rst;
    logic       sym_valid;
    logic [1:0] sym_data;
    logic       sym_ready;
    logic       out_valid;
    logic [3:0] cos_addr;
    logic [3:0] sin_addr;
    logic       sym_start;
    logic       starve;
    logic [7:0] underflow_cnt;

    qpsk_carrier_ctrl #(.PERIODS_PER_SYM(P), .ADDR_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .sym_valid     (sym_valid),
        .sym_data      (sym_data),
        .sym_ready     (sym_ready),
        .out_valid     (out_valid),
        .cos_addr      (cos_addr),
        .sin_addr      (sin_addr),
        .sym_start     (sym_start),
        .starve        (starve),
        .underflow_cnt (underflow_cnt)
    );

    // Free-running sample clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Phase table indexed by the symbol value: 00,01,10,11
    int phase_tab [4] = '{2, 6, 14, 10};

`ifdef QPSK_UNDERFLOW_CNT_EN
    localparam int UF_FINAL = 255;
`else
    localparam int UF_FINAL = 0;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: queue of accepted symbols, the symbol now playing and its sample position
    logic [1:0] m_q [$];
    logic [1:0] sb_q [$];
    bit         m_busy  = 1'b0;
    int         m_pos   = 0;
    logic [1:0] m_cur   = 2'b00;
    bit         e_valid = 1'b0;
    int         e_cos   = 0;
    bit         e_start = 1'b0;
    bit         e_starve = 1'b0;
    int         e_uf    = 0;

    // Model advances on each clock edge, reset wipes it immediately
    always @(posedge clk or posedge rst) begin
        bit n_valid;
        int n_cos;
        bit n_start;
        bit n_starve;
        bit accept;
        if (rst) begin
            m_q.delete();
            sb_q.delete();
            m_busy   = 1'b0;
            m_pos    = 0;
            e_valid  = 1'b0;
            e_cos    = 0;
            e_start  = 1'b0;
            e_starve = 1'b0;
            e_uf     = 0;
        end else begin
            n_valid  = m_busy;
            n_cos    = ((m_pos % 16) + phase_tab[m_cur]) % 16;
            n_start  = m_busy && (m_pos == 0);
            n_starve = e_valid && !n_valid;
`ifdef QPSK_UNDERFLOW_CNT_EN
            if (e_starve && e_uf < 255) e_uf++;
`endif
            accept = sym_valid && (m_q.size() < 2);
            if (!m_busy) begin
                if (m_q.size() > 0) begin
                    m_cur  = m_q.pop_front();
                    m_busy = 1'b1;
                    m_pos  = 0;
                end
            end else if (m_pos == SYM_LEN - 1) begin
                if (m_q.size() > 0) begin
                    m_cur = m_q.pop_front();
                    m_pos = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end else begin
                m_pos++;
            end
            if (accept) begin
                m_q.push_back(sym_data);
                sb_q.push_back(sym_data);
            end
            e_valid  = n_valid;
            e_cos    = n_cos;
            e_start  = n_start;
            e_starve = n_starve;
        end
    end

    // Per-cycle compare of every DUT output against the model, mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("sym_ready", sym_ready, (!rst && m_q.size() < 2));
            checkOutput("out_valid", out_valid, e_valid);
            if (e_valid) begin
                checkOutput("cos_addr", cos_addr, e_cos);
                checkOutput("sin_addr", sin_addr, (e_cos + 12) % 16);
            end
            checkOutput("sym_start", sym_start, e_start);
            checkOutput("starve", starve, e_starve);
            checkOutput("underflow_cnt", underflow_cnt, e_uf);
        end
    end

    // Scoreboard: every symbol start must be the oldest accepted symbol not yet played
    always @(negedge clk) begin
        logic [1:0] want;
        if (chk_en && !rst && out_valid && sym_start) begin
            if (sb_q.size() == 0) begin
                checkOutput("sb_unexpected_symbol", 1, 0);
            end else begin
                want = sb_q.pop_front();
                checkOutput("sb_symbol", cos_addr, phase_tab[want]);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [1:0] d, output logic acc);
        @(negedge clk);
        sym_valid = v;
        sym_data  = d;
        acc = v && sym_ready;
    endtask

    task automatic pushSymbol(input logic [1:0] d);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            applyStimulus(1'b1, d, acc);
        end
        if (!acc) checkOutput("push_timeout", 0, 1);
    endtask

    task automatic idleCycles(input int n);
        logic acc;
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'b00, acc);
    endtask

    bit       cap_v  [64];
    bit [3:0] cap_c  [64];
    bit [3:0] cap_s  [64];
    bit       cap_st [64];
    bit       cap_sv [64];

    // Idle until the first valid sample, then record n cycles of outputs
    task automatic captureRun(input int n, output int lat);
        logic acc;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b0, 2'b00, acc);
            if (out_valid) begin
                lat = k - 1;
                break;
            end
        end
        if (lat < 0) begin
            checkOutput("first_valid_timeout", 0, 1);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (i > 0) applyStimulus(1'b0, 2'b00, acc);
                cap_v[i]  = out_valid;
                cap_c[i]  = cos_addr;
                cap_s[i]  = sin_addr;
                cap_st[i] = sym_start;
                cap_sv[i] = starve;
            end
        end
    endtask

    int lat;
    int run_len;
    int valid_seen;
    bit saw_low;
    bit got_starve;
    logic acc;

    initial begin
        rst       = 1'b1;
        sym_valid = 1'b0;
        sym_data  = 2'b00;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        checkOutput("ready_after_release", sym_ready, 1);

        // Asynchronous reset while idle: immediate, no clock edge needed
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_ready", sym_ready, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_cos", cos_addr, 0);
        checkOutput("rst_sin", sin_addr, 12);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 checkOutput("rst_release_ready", sym_ready, 1);

        // Single symbol 00
        $display("[TB] single symbol");
        pushSymbol(2'b00);
        captureRun(20, lat);
        checkOutput("single_latency", lat, 2);
        run_len = 0;
        for (int i = 0; i < 20; i++) if (cap_v[i]) run_len++;
        checkOutput("single_valid_len", run_len, 16);
        checkOutput("single_cos0", cap_c[0], 2);
        checkOutput("single_sin0", cap_s[0], 14);
        checkOutput("single_cos13", cap_c[13], 15);
        checkOutput("single_cos14", cap_c[14], 0);
        checkOutput("single_cos15", cap_c[15], 1);
        checkOutput("single_sin15", cap_s[15], 13);
        checkOutput("single_start0", cap_st[0], 1);
        checkOutput("single_start1", cap_st[1], 0);
        checkOutput("single_starve15", cap_sv[15], 0);
        checkOutput("single_valid16", cap_v[16], 0);
        checkOutput("single_starve16", cap_sv[16], 1);
        checkOutput("single_starve17", cap_sv[17], 0);
        idleCycles(3);

        // Back-to-back symbols 01 then 11
        $display("[TB] back-to-back");
        pushSymbol(2'b01);
        pushSymbol(2'b11);
        captureRun(36, lat);
        run_len = 0;
        for (int i = 0; i < 36 && cap_v[i]; i++) run_len++;
        checkOutput("b2b_valid_run", run_len, 32);
        checkOutput("b2b_cos0", cap_c[0], 6);
        checkOutput("b2b_cos16", cap_c[16], 10);
        checkOutput("b2b_start16", cap_st[16], 1);
        checkOutput("b2b_start15", cap_st[15], 0);
        checkOutput("b2b_starve16", cap_sv[16], 0);
        checkOutput("b2b_starve32", cap_sv[32], 1);
        idleCycles(3);

        // Full buffer: hold valid with random data until 20 symbols accepted
        $display("[TB] full buffer");
        saw_low = 1'b0;
        begin
            int accepted;
            accepted = 0;
            for (int k = 0; k < 2000 && accepted < 20; k++) begin
                if (!sym_ready) saw_low = 1'b1;
                applyStimulus(1'b1, 2'($urandom_range(0, 3)), acc);
                if (acc) accepted++;
            end
            checkOutput("full_accepted", accepted, 20);
        end
        idleCycles(60);
        checkOutput("full_ready_dropped", saw_low, 1);
        checkOutput("full_sb_drained", sb_q.size(), 0);

        // Reset mid-symbol: symbol 10 playing at sample 7, symbol 01 buffered
        $display("[TB] reset mid-symbol");
        pushSymbol(2'b10);
        pushSymbol(2'b01);
        captureRun(1, lat);
        idleCycles(7);
        checkOutput("mid_cos_sample7", cos_addr, 5);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_cos", cos_addr, 0);
        checkOutput("mid_rst_sin", sin_addr, 12);
        checkOutput("mid_rst_ready", sym_ready, 0);
        checkOutput("mid_rst_starve", starve, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        valid_seen = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b0, 2'b00, acc);
            if (out_valid || starve) valid_seen++;
        end
        checkOutput("mid_no_ghost_output", valid_seen, 0);

        // Random traffic with random gaps
        $display("[TB] random traffic");
        for (int k = 0; k < 600; k++) begin
            applyStimulus(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), acc);
        end
        idleCycles(60);
        checkOutput("rand_sb_drained", sb_q.size(), 0);

        // Isolated bursts to drive the starve counter
        $display("[TB] underflow bursts");
        for (int b = 0; b < 300; b++) begin
            pushSymbol(2'($urandom_range(0, 3)));
            got_starve = 1'b0;
            for (int k = 0; k < 60 && !got_starve; k++) begin
                applyStimulus(1'b0, 2'b00, acc);
                if (starve) got_starve = 1'b1;
            end
            if (!got_starve) checkOutput("starve_timeout", 0, 1);
        end
        idleCycles(3);
        checkOutput("uf_final", underflow_cnt, UF_FINAL);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
